// File: rtl/axi_byte_target.sv
// AXI4-Lite byte-wide scratch memory target with independent AW/W holders,
// single-entry B and R response registers and a saturating decode-error counter.
//
// B channel states
//   state  | meaning
//   B_IDLE | no write response outstanding; AW/W holders may accept
//   B_RESP | bvalid high, bresp held until bready
module axi_byte_target #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        s_areset,

    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [2:0]  s_axi_awsize,

    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,

    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,

    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [2:0]  s_axi_arsize,

    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,

    output logic [7:0]  err_count
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        B_IDLE = 1'b0,
        B_RESP = 1'b1
    } b_state_t;

    b_state_t    r_b_state;
    logic [1:0]  r_bresp;
    logic        r_aw_full;
    logic [31:0] r_aw_addr;
    logic        r_w_full;
    logic [7:0]  r_w_data;
    logic        r_w_strb0;

    logic        r_rvalid;
    logic [7:0]  r_rdata;
    logic [1:0]  r_rresp;
    logic [7:0]  r_err_count;

    logic [7:0]  r_mem [0:DEPTH-1];

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_commit;
    logic [31:0] w_wr_addr;
    logic [7:0]  w_wr_data;
    logic        w_wr_strb0;
    logic        w_wr_ok;
    logic        w_rd_ok;
    logic [1:0]  w_err_inc;
    logic [8:0]  w_err_sum;
    logic        w_unused;

    // Size fields, upper data lanes and upper strobes carry nothing for a byte target.
    assign w_unused = ^{s_axi_awsize, s_axi_arsize, s_axi_wdata[31:8], s_axi_wstrb[3:1]};

    assign s_axi_awready = !s_areset && !r_aw_full && (r_b_state == B_IDLE);
    assign s_axi_wready  = !s_areset && !r_w_full  && (r_b_state == B_IDLE);
    assign s_axi_arready = !s_areset && !r_rvalid;

    assign w_aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_w_hs  = s_axi_wvalid  && s_axi_wready;
    assign w_ar_hs = s_axi_arvalid && s_axi_arready;

    // A commit may use either a latched beat or one handshaking this cycle.
    assign w_wr_addr  = r_aw_full ? r_aw_addr : s_axi_awaddr;
    assign w_wr_data  = r_w_full  ? r_w_data  : s_axi_wdata[7:0];
    assign w_wr_strb0 = r_w_full  ? r_w_strb0 : s_axi_wstrb[0];
    assign w_commit   = (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);

    assign w_wr_ok = (w_wr_addr >> ADDR_BITS) == 32'd0;
    assign w_rd_ok = (s_axi_araddr >> ADDR_BITS) == 32'd0;

    assign w_err_inc = {1'b0, w_commit && !w_wr_ok} + {1'b0, w_ar_hs && !w_rd_ok};
    assign w_err_sum = {1'b0, r_err_count} + {7'd0, w_err_inc};

    always_ff @(posedge clk) begin
        if (s_areset) begin
            r_b_state <= B_IDLE;
            r_bresp   <= RESP_OKAY;
            r_aw_full <= 1'b0;
            r_aw_addr <= 32'd0;
            r_w_full  <= 1'b0;
            r_w_data  <= 8'd0;
            r_w_strb0 <= 1'b0;
        end else begin
            case (r_b_state)
                B_IDLE: begin
                    if (w_commit) begin
                        r_b_state <= B_RESP;
                        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                B_RESP: begin
                    if (s_axi_bready) begin
                        r_b_state <= B_IDLE;
                    end
                end
                default: r_b_state <= B_IDLE;
            endcase

            if (w_commit) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end else begin
                if (w_aw_hs) begin
                    r_aw_full <= 1'b1;
                    r_aw_addr <= s_axi_awaddr;
                end
                if (w_w_hs) begin
                    r_w_full  <= 1'b1;
                    r_w_data  <= s_axi_wdata[7:0];
                    r_w_strb0 <= s_axi_wstrb[0];
                end
            end
        end
    end

    // Memory has no reset; a read in the commit cycle sees the old byte.
    always_ff @(posedge clk) begin
        if (!s_areset && w_commit && w_wr_ok && w_wr_strb0) begin
            r_mem[w_wr_addr[ADDR_BITS-1:0]] <= w_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (s_areset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 8'd0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_ok ? r_mem[s_axi_araddr[ADDR_BITS-1:0]] : 8'd0;
            r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (s_areset) begin
            r_err_count <= 8'd0;
        end else begin
            r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign s_axi_bvalid = (r_b_state == B_RESP);
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rdata  = {24'd0, r_rdata};
    assign s_axi_rresp  = r_rresp;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_axi_byte_target.sv
// Self-checking bench for axi_byte_target: directed scenarios plus randomized
// traffic against a byte-array reference model with a saturating error tally.
module tb_axi_byte_target;

    logic        clk = 1'b0;
    logic        s_areset;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    axi_byte_target #(.ADDR_BITS(8)) dut (
        .clk           (clk),
        .s_areset      (s_areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awsize  (3'b000),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_arsize  (3'b000),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .err_count     (err_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [256];
    bit         known   [256];
    int         ref_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void err_bump();
        if (ref_err < 255) ref_err++;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a < 256) begin
            if (s[0]) begin
                ref_mem[a[7:0]] = d[7:0];
                known[a[7:0]]   = 1'b1;
            end
        end else begin
            err_bump();
        end
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return (a < 256) ? 2'b00 : 2'b10;
    endfunction

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_now, w_now;
        int k = 0;
        s_axi_awaddr = a;
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        while (!(aw_done && w_done) && k < 50) begin
            @(negedge clk);
            s_axi_awvalid = !aw_done && (k >= aw_dly);
            s_axi_wvalid  = !w_done  && (k >= w_dly);
            #1;
            aw_now = s_axi_awvalid && s_axi_awready;
            w_now  = s_axi_wvalid  && s_axi_wready;
            @(posedge clk);
            aw_done = aw_done || aw_now;
            w_done  = w_done  || w_now;
            k++;
        end
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("wr_handshake_timeout", 0, 1);
            return;
        end
        model_write(a, d, s);
        check("b_latency", s_axi_bvalid, 1);
        check("bresp", s_axi_bresp, exp_resp(a));
        check("wr_err_count", err_count, ref_err);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check("b_hold", {s_axi_bvalid, s_axi_bresp}, {1'b1, exp_resp(a)});
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("b_done", s_axi_bvalid, 0);
    endtask

    task automatic axi_read(input logic [31:0] a, input int r_dly);
        bit ar_done = 0;
        bit ar_now;
        int k = 0;
        logic [1:0] er;
        s_axi_araddr = a;
        while (!ar_done && k < 50) begin
            @(negedge clk);
            s_axi_arvalid = 1'b1;
            #1;
            ar_now = s_axi_arready;
            @(posedge clk);
            ar_done = ar_now;
            k++;
        end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        if (!ar_done) begin
            check("rd_handshake_timeout", 0, 1);
            return;
        end
        er = exp_resp(a);
        if (a >= 256) err_bump();
        check("r_latency", s_axi_rvalid, 1);
        check("rresp", s_axi_rresp, er);
        if (a >= 256)
            check("rdata_err", s_axi_rdata, 0);
        else if (known[a[7:0]])
            check("rdata", s_axi_rdata, {24'd0, ref_mem[a[7:0]]});
        check("rd_err_count", err_count, ref_err);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check("r_hold_valid", s_axi_rvalid, 1);
            check("r_hold_resp", s_axi_rresp, er);
        end
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        check("r_done", s_axi_rvalid, 0);
    endtask

    initial begin
        logic [31:0] ra;
        s_areset      = 1'b1;
        s_axi_awaddr  = 0; s_axi_awvalid = 0;
        s_axi_wdata   = 0; s_axi_wstrb   = 0; s_axi_wvalid = 0;
        s_axi_bready  = 0;
        s_axi_araddr  = 0; s_axi_arvalid = 0; s_axi_rready = 0;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_awready", s_axi_awready, 0);
        check("rst_arready", s_axi_arready, 0);
        s_areset = 1'b0;
        #1;
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_rvalid", s_axi_rvalid, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_err", err_count, 0);
        check("rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // basic write then read
        axi_write(32'h05, 32'h0000_00A5, 4'b0001, 0, 0, 0);
        axi_write(32'h00, 32'hDEAD_BE5E, 4'b1111, 0, 1, 0);
        axi_read(32'h05, 0);
        check("basic_err", err_count, 0);

        // W three cycles ahead of AW
        @(negedge clk);
        s_axi_wdata = 32'h3C; s_axi_wstrb = 4'b0001; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        check("ord_wready_low", s_axi_wready, 0);
        check("ord_awready", s_axi_awready, 1);
        repeat (2) begin
            @(negedge clk);
            check("ord_wait", {s_axi_awready, s_axi_wready, s_axi_bvalid}, 3'b100);
        end
        s_axi_awaddr = 32'h10; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        model_write(32'h10, 32'h3C, 4'b0001);
        check("ord_bvalid", s_axi_bvalid, 1);
        check("ord_bresp", s_axi_bresp, 0);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        axi_read(32'h10, 0);

        // decode errors
        axi_write(32'h100, 32'h77, 4'b0001, 0, 0, 0);
        axi_read(32'h1FF, 0);
        check("dec_err_count", err_count, 2);
        axi_read(32'h00, 0);

        // backpressure: write and read accepted together, responses held
        @(negedge clk);
        s_axi_awaddr = 32'h30; s_axi_wdata = 32'h5A; s_axi_wstrb = 4'b0001;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        s_axi_araddr = 32'h05; s_axi_arvalid = 1;
        @(negedge clk);
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        model_write(32'h30, 32'h5A, 4'b0001);
        repeat (5) begin
            check("bp_b", {s_axi_bvalid, s_axi_bresp}, 3'b100);
            check("bp_r", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, 2'b00, 32'hA5});
            check("bp_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
            @(negedge clk);
        end
        s_axi_bready = 1; s_axi_rready = 1;
        @(negedge clk);
        s_axi_bready = 0; s_axi_rready = 0;
        check("bp_release", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        check("bp_ready_back", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // same-cycle read/write collision
        axi_write(32'h20, 32'h11, 4'b0001, 0, 0, 0);
        @(negedge clk);
        s_axi_awaddr = 32'h20; s_axi_wdata = 32'h22; s_axi_wstrb = 4'b0001;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        s_axi_araddr = 32'h20; s_axi_arvalid = 1;
        @(negedge clk);
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        check("col_rdata_old", s_axi_rdata, {24'd0, ref_mem[8'h20]});
        model_write(32'h20, 32'h22, 4'b0001);
        s_axi_bready = 1; s_axi_rready = 1;
        @(negedge clk);
        s_axi_bready = 0; s_axi_rready = 0;
        axi_read(32'h20, 0);

        // read error and write error in the same cycle
        @(negedge clk);
        s_axi_awaddr = 32'h100; s_axi_wdata = 32'h01; s_axi_wstrb = 4'b0001;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        s_axi_araddr = 32'h1FF; s_axi_arvalid = 1;
        @(negedge clk);
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        err_bump(); err_bump();
        check("dual_err_count", err_count, ref_err);
        check("dual_resp", {s_axi_bresp, s_axi_rresp}, 4'b1010);
        s_axi_bready = 1; s_axi_rready = 1;
        @(negedge clk);
        s_axi_bready = 0; s_axi_rready = 0;

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            ra = ($urandom_range(9) == 0) ? (32'h100 + $urandom_range(32'hFFFF)) : $urandom_range(255);
            if ($urandom_range(1) == 0)
                axi_write(ra, $urandom, 4'($urandom_range(15)),
                          $urandom_range(3), $urandom_range(3), $urandom_range(2));
            else
                axi_read(ra, $urandom_range(2));
        end

        // reset abandons a latched AW and a pending R
        axi_write(32'h40, 32'h77, 4'b0001, 0, 0, 0);
        axi_write(32'h41, 32'h66, 4'b0001, 0, 0, 0);
        @(negedge clk);
        s_axi_awaddr = 32'h40; s_axi_awvalid = 1;
        s_axi_araddr = 32'h41; s_axi_arvalid = 1;
        @(negedge clk);
        s_axi_awvalid = 0; s_axi_arvalid = 0;
        check("pre_rst_rvalid", s_axi_rvalid, 1);
        check("pre_rst_awready", s_axi_awready, 0);
        s_areset = 1;
        #1;
        check("in_rst_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        @(negedge clk);
        s_areset = 0;
        ref_err = 0;
        #1;
        check("post_rst_valid", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        check("post_rst_err", err_count, 0);
        check("post_rst_awready", s_axi_awready, 1);
        s_axi_wdata = 32'h99; s_axi_wstrb = 4'b0001; s_axi_wvalid = 1;
        @(negedge clk);
        s_axi_wvalid = 0;
        check("rst_w_latched", s_axi_wready, 0);
        repeat (3) begin
            check("rst_w_waits", s_axi_bvalid, 0);
            @(negedge clk);
        end
        s_axi_awaddr = 32'h41; s_axi_awvalid = 1;
        @(negedge clk);
        s_axi_awvalid = 0;
        model_write(32'h41, 32'h99, 4'b0001);
        check("rst_fresh_aw_b", s_axi_bvalid, 1);
        s_axi_bready = 1;
        @(negedge clk);
        s_axi_bready = 0;
        axi_read(32'h40, 0);
        axi_read(32'h41, 0);

        // drive the error counter into saturation
        while (ref_err < 255) axi_read(32'h200, 0);
        axi_read(32'h300, 0);
        axi_write(32'h400, 32'h1, 4'b0001, 0, 0, 0);
        check("sat_err_count", err_count, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
